// File: rtl/timer_set_ctrl.sv
// timer_set_ctrl: button-driven edit/commit controller for the calendar timer.
// Optional auto-repeat on a held inc button: define TIMER_SET_AUTO_REPEAT_EN.
module timer_set_ctrl #(
   parameter int IDLE_TO    = 1000,
   parameter int REPEAT_DLY = 8,
   parameter int REPEAT_PER = 2
) (
   input  logic        clk,
   input  logic        glob_rst_n,
   input  logic        btn_mode,
   input  logic        btn_inc,
   input  logic [5:0]  cur_sec,
   input  logic [5:0]  cur_min,
   input  logic [4:0]  cur_hour,
   input  logic [4:0]  cur_day,
   input  logic [3:0]  cur_mon,
   input  logic [13:0] cur_year,
   output logic        hold,
   output logic [2:0]  field_sel,
   output logic        ld,
   output logic [5:0]  ld_sec,
   output logic [5:0]  ld_min,
   output logic [4:0]  ld_hour,
   output logic [4:0]  ld_day,
   output logic [3:0]  ld_mon,
   output logic [13:0] ld_year
);

   typedef enum logic [2:0] {
      S_RUN  = 3'd0,
      S_YEAR = 3'd1,
      S_MON  = 3'd2,
      S_DAY  = 3'd3,
      S_HOUR = 3'd4,
      S_MIN  = 3'd5,
      S_SEC  = 3'd6
   } state_t;

   localparam int IW = $clog2(IDLE_TO + 1);

   // Reject parameter values that would break the counters
   if (IDLE_TO < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
      $error("timer_set_ctrl: bad counter parameters");
   end

   state_t         state_q, state_d;
   logic           hold_q;
   logic           ld_q, ld_d;
   logic           mode_q, inc_q;
   logic           mode_p, inc_p, inc_ev;
   logic [IW-1:0]  idle_q, idle_d;
   logic [5:0]     sec_d, min_d;
   logic [4:0]     hour_d, day_d;
   logic [3:0]     mon_d;
   logic [13:0]    year_d;
   logic [4:0]     dim_cur;

   function automatic logic [4:0] dim(input logic [3:0] m, input logic [13:0] y);
      logic leap;
      logic [4:0] r;
      leap = ((y % 14'd4) == 14'd0) &&
             (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
      case (m)
         4'd2:                    r = leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: r = 5'd30;
         default:                 r = 5'd31;
      endcase
      return r;
   endfunction

   assign mode_p  = btn_mode & ~mode_q;
   assign inc_p   = btn_inc & ~inc_q;
   assign dim_cur = dim(ld_mon, ld_year);

`ifdef TIMER_SET_AUTO_REPEAT_EN
   logic [15:0] rpt_q, rpt_d;
   logic        rpt_fire;

   // Hold-to-repeat: first repeat after REPEAT_DLY, then every REPEAT_PER
   always_comb begin
      rpt_d    = rpt_q;
      rpt_fire = 1'b0;
      if (inc_p) begin
         rpt_d = 16'(REPEAT_DLY - 1);
      end else if (btn_inc && state_q != S_RUN) begin
         if (rpt_q == 16'd0) begin
            rpt_fire = 1'b1;
            rpt_d    = 16'(REPEAT_PER - 1);
         end else begin
            rpt_d = rpt_q - 16'd1;
         end
      end
   end

   // Repeat countdown register
   always_ff @(posedge clk) begin
      if (!glob_rst_n) rpt_q <= '0;
      else             rpt_q <= rpt_d;
   end

   assign inc_ev = inc_p | rpt_fire;
`else
   assign inc_ev = inc_p;
`endif

   // Next state, edit values, load strobe and idle counter
   always_comb begin
      state_d = state_q;
      ld_d    = 1'b0;
      idle_d  = idle_q;
      sec_d   = ld_sec;
      min_d   = ld_min;
      hour_d  = ld_hour;
      day_d   = ld_day;
      mon_d   = ld_mon;
      year_d  = ld_year;
      case (state_q)
         S_RUN: begin
            idle_d = '0;
            if (mode_p) begin
               sec_d   = (cur_sec > 6'd59) ? 6'd0 : cur_sec;
               min_d   = (cur_min > 6'd59) ? 6'd0 : cur_min;
               hour_d  = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
               day_d   = (cur_day == 5'd0) ? 5'd1 : cur_day;
               mon_d   = (cur_mon == 4'd0 || cur_mon > 4'd12) ? 4'd1 : cur_mon;
               year_d  = (cur_year > 14'd9999) ? 14'd0 : cur_year;
               state_d = S_YEAR;
            end
         end
         S_YEAR, S_MON, S_DAY, S_HOUR, S_MIN, S_SEC: begin
            if (mode_p) begin
               idle_d = '0;
               case (state_q)
                  S_YEAR: state_d = S_MON;
                  S_MON: begin
                     state_d = S_DAY;
                     if (ld_day > dim_cur) day_d = dim_cur;
                  end
                  S_DAY:  state_d = S_HOUR;
                  S_HOUR: state_d = S_MIN;
                  S_MIN:  state_d = S_SEC;
                  default: begin
                     state_d = S_RUN;
                     ld_d    = 1'b1;
                  end
               endcase
            end else if (inc_ev) begin
               idle_d = '0;
               case (state_q)
                  S_YEAR: year_d = (ld_year >= 14'd9999) ? 14'd0 : ld_year + 14'd1;
                  S_MON:  mon_d  = (ld_mon >= 4'd12) ? 4'd1 : ld_mon + 4'd1;
                  S_DAY:  day_d  = (ld_day >= dim_cur) ? 5'd1 : ld_day + 5'd1;
                  S_HOUR: hour_d = (ld_hour >= 5'd23) ? 5'd0 : ld_hour + 5'd1;
                  S_MIN:  min_d  = (ld_min >= 6'd59) ? 6'd0 : ld_min + 6'd1;
                  default: sec_d = (ld_sec >= 6'd59) ? 6'd0 : ld_sec + 6'd1;
               endcase
            end else if (inc_p || btn_mode & ~mode_q) begin
               idle_d = '0;
            end else if (idle_q == IW'(IDLE_TO - 1)) begin
               idle_d  = '0;
               state_d = S_RUN;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         default: begin
            idle_d  = '0;
            state_d = S_RUN;
         end
      endcase
   end

   // State, hold, strobe, edit registers and button history
   always_ff @(posedge clk) begin
      if (!glob_rst_n) begin
         state_q <= S_RUN;
         hold_q  <= 1'b0;
         ld_q    <= 1'b0;
         idle_q  <= '0;
         mode_q  <= 1'b0;
         inc_q   <= 1'b0;
         ld_sec  <= 6'd0;
         ld_min  <= 6'd0;
         ld_hour <= 5'd0;
         ld_day  <= 5'd1;
         ld_mon  <= 4'd1;
         ld_year <= 14'd0;
      end else begin
         state_q <= state_d;
         hold_q  <= (state_d != S_RUN);
         ld_q    <= ld_d;
         idle_q  <= idle_d;
         mode_q  <= btn_mode;
         inc_q   <= btn_inc;
         ld_sec  <= sec_d;
         ld_min  <= min_d;
         ld_hour <= hour_d;
         ld_day  <= day_d;
         ld_mon  <= mon_d;
         ld_year <= year_d;
      end
   end

   assign hold      = hold_q;
   assign ld        = ld_q;
   assign field_sel = state_q;

endmodule

// File: tb/tb_timer_set_ctrl.sv
// tb_timer_set_ctrl: scoreboard bench for timer_set_ctrl.
// Expected values are queued with the stimulus and drained at the sample point.
module tb_timer_set_ctrl;

   logic        clk = 1'b0;
   logic        glob_rst_n;
   logic        btn_mode, btn_inc;
   logic [5:0]  cur_sec, cur_min;
   logic [4:0]  cur_hour, cur_day;
   logic [3:0]  cur_mon;
   logic [13:0] cur_year;
   logic        hold, ld;
   logic [2:0]  field_sel;
   logic [5:0]  ld_sec, ld_min;
   logic [4:0]  ld_hour, ld_day;
   logic [3:0]  ld_mon;
   logic [13:0] ld_year;

   timer_set_ctrl #(
      .IDLE_TO(1000), .REPEAT_DLY(8), .REPEAT_PER(2)
   ) dut (
      .clk(clk), .glob_rst_n(glob_rst_n),
      .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
      .cur_day(cur_day), .cur_mon(cur_mon), .cur_year(cur_year),
      .hold(hold), .field_sel(field_sel), .ld(ld),
      .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
      .ld_day(ld_day), .ld_mon(ld_mon), .ld_year(ld_year)
   );

   always #5 clk = ~clk;

   localparam int O_SEL = 0, O_HOLD = 1, O_LD = 2, O_SEC = 3, O_MIN = 4;
   localparam int O_HOUR = 5, O_DAY = 6, O_MON = 7, O_YEAR = 8, O_LDCNT = 9;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   nvec = 0;
   int   nerr = 0;
   int   ld_cnt = 0;
   int   exp_ld = 0;

   // Count every ld pulse, sampled just after the edge that raised it
   always begin
      @(posedge clk);
      #1;
      if (ld) ld_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         O_SEL:   return 32'(field_sel);
         O_HOLD:  return 32'(hold);
         O_LD:    return 32'(ld);
         O_SEC:   return 32'(ld_sec);
         O_MIN:   return 32'(ld_min);
         O_HOUR:  return 32'(ld_hour);
         O_DAY:   return 32'(ld_day);
         O_MON:   return 32'(ld_mon);
         O_YEAR:  return 32'(ld_year);
         default: return 32'(ld_cnt);
      endcase
   endfunction

   task automatic push_exp(input string tag, input int sel, input int val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = 32'(val);
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, observe(e.sel), e.val);
      end
   endtask

   task automatic set_cur(input int y, input int m, input int d,
                          input int h, input int mi, input int s);
      cur_year = 14'(y);
      cur_mon  = 4'(m);
      cur_day  = 5'(d);
      cur_hour = 5'(h);
      cur_min  = 6'(mi);
      cur_sec  = 6'(s);
   endtask

   task automatic press(input logic m, input logic i);
      @(negedge clk);
      btn_mode = m;
      btn_inc  = i;
      @(negedge clk);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      glob_rst_n = 1'b0;
      btn_mode   = 1'b0;
      btn_inc    = 1'b0;
      repeat (2) @(negedge clk);
      glob_rst_n = 1'b1;
   endtask

   task automatic push_reset_state(input string t);
      push_exp({t, "_sel"}, O_SEL, 0);
      push_exp({t, "_hold"}, O_HOLD, 0);
      push_exp({t, "_ld"}, O_LD, 0);
      push_exp({t, "_day"}, O_DAY, 1);
      push_exp({t, "_mon"}, O_MON, 1);
      push_exp({t, "_year"}, O_YEAR, 0);
   endtask

   initial begin
      glob_rst_n = 1'b0;
      btn_mode   = 1'b0;
      btn_inc    = 1'b0;
      set_cur(2023, 2, 28, 23, 59, 58);

      do_reset();
      push_reset_state("rst");
      push_exp("rst_sec", O_SEC, 0);
      drain();

      // inc in RUN is ignored
      press(1'b0, 1'b1);
      push_exp("runinc_sel", O_SEL, 0);
      push_exp("runinc_year", O_YEAR, 0);
      drain();

      // full edit 2023/02/28 23:59:58 -> 2024/02/01 23:59:58
      press(1'b1, 1'b0);
      push_exp("fe_sel_year", O_SEL, 1);
      push_exp("fe_hold", O_HOLD, 1);
      push_exp("fe_snap_year", O_YEAR, 2023);
      drain();
      press(1'b0, 1'b1);
      push_exp("fe_year_inc", O_YEAR, 2024);
      drain();
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      push_exp("fe_sel_day", O_SEL, 3);
      push_exp("fe_day28", O_DAY, 28);
      drain();
      press(1'b0, 1'b1);
      push_exp("fe_day29", O_DAY, 29);
      drain();
      press(1'b0, 1'b1);
      push_exp("fe_day1", O_DAY, 1);
      drain();
      repeat (3) press(1'b1, 1'b0);
      push_exp("fe_sel_sec", O_SEL, 6);
      push_exp("fe_ld_pre", O_LD, 0);
      drain();
      press(1'b1, 1'b0);
      exp_ld++;
      push_exp("fe_sel_run", O_SEL, 0);
      push_exp("fe_hold_drop", O_HOLD, 0);
      push_exp("fe_ld", O_LD, 1);
      push_exp("fe_ld_year", O_YEAR, 2024);
      push_exp("fe_ld_mon", O_MON, 2);
      push_exp("fe_ld_day", O_DAY, 1);
      push_exp("fe_ld_hour", O_HOUR, 23);
      push_exp("fe_ld_min", O_MIN, 59);
      push_exp("fe_ld_sec", O_SEC, 58);
      push_exp("fe_ldcnt", O_LDCNT, exp_ld);
      drain();
      @(negedge clk);
      push_exp("fe_ld_one", O_LD, 0);
      push_exp("fe_ldcnt2", O_LDCNT, exp_ld);
      drain();

      // reset mid-edit gives reset values and no ld
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      do_reset();
      push_reset_state("rstedit");
      push_exp("rstedit_ldcnt", O_LDCNT, exp_ld);
      drain();

      // clamp: 2023/01/31, month -> 2, DAY gives 28
      set_cur(2023, 1, 31, 10, 0, 0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      push_exp("clamp_mon", O_MON, 2);
      drain();
      press(1'b1, 1'b0);
      push_exp("clamp_day", O_DAY, 28);
      drain();
      do_reset();

      // 1900 not leap
      set_cur(1900, 2, 29, 0, 0, 0);
      repeat (3) press(1'b1, 1'b0);
      push_exp("leap1900_day", O_DAY, 28);
      drain();
      do_reset();

      // 2000 is leap
      set_cur(2000, 2, 29, 0, 0, 0);
      repeat (3) press(1'b1, 1'b0);
      push_exp("leap2000_day", O_DAY, 29);
      drain();
      do_reset();

      // out-of-range snapshot is sanitized
      set_cur(12000, 0, 0, 30, 63, 60);
      press(1'b1, 1'b0);
      push_exp("san_year", O_YEAR, 0);
      push_exp("san_mon", O_MON, 1);
      push_exp("san_day", O_DAY, 1);
      push_exp("san_hour", O_HOUR, 0);
      push_exp("san_min", O_MIN, 0);
      push_exp("san_sec", O_SEC, 0);
      drain();
      do_reset();

      // wrap on every field, then commit
      set_cur(9999, 12, 15, 23, 59, 59);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      push_exp("wrap_year", O_YEAR, 0);
      drain();
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      push_exp("wrap_mon", O_MON, 1);
      drain();
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      push_exp("wrap_hour", O_HOUR, 0);
      drain();
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      push_exp("wrap_min", O_MIN, 0);
      drain();
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      push_exp("wrap_sec", O_SEC, 0);
      drain();
      press(1'b1, 1'b0);
      exp_ld++;
      push_exp("wrap_ld", O_LD, 1);
      push_exp("wrap_ld_day", O_DAY, 15);
      push_exp("wrap_ldcnt", O_LDCNT, exp_ld);
      drain();

      // mode and inc together: mode wins
      set_cur(2030, 5, 5, 5, 5, 5);
      press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      push_exp("simul_sel", O_SEL, 2);
      push_exp("simul_year", O_YEAR, 2030);
      drain();
      do_reset();

      // idle timeout returns to RUN with no ld
      set_cur(2011, 3, 3, 3, 3, 3);
      press(1'b1, 1'b0);
      repeat (990) @(negedge clk);
      push_exp("idle_still_set", O_SEL, 1);
      drain();
      repeat (20) @(negedge clk);
      push_exp("idle_sel", O_SEL, 0);
      push_exp("idle_hold", O_HOLD, 0);
      push_exp("idle_keep_year", O_YEAR, 2011);
      push_exp("idle_ldcnt", O_LDCNT, exp_ld);
      drain();

      // held inc in MIN for 14 cycles
      set_cur(2011, 3, 3, 3, 10, 3);
      repeat (5) press(1'b1, 1'b0);
      push_exp("rpt_sel_min", O_SEL, 5);
      drain();
      @(negedge clk);
      btn_inc = 1'b1;
      repeat (14) @(negedge clk);
      btn_inc = 1'b0;
`ifdef TIMER_SET_AUTO_REPEAT_EN
      push_exp("rpt_min", O_MIN, 14);
`else
      push_exp("rpt_min", O_MIN, 11);
`endif
      drain();
      @(negedge clk);
      push_exp("rpt_ldcnt", O_LDCNT, exp_ld);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
